// File: rtl/seq_decoder.sv
// seq_decoder: instruction decoder for the 16-bit pcpu core.
// A step FSM owns every multi-cycle sequence (loads, pop, call/ret,
// interrupt entry/return). All control outputs are combinational from
// the step state, the ie bit and the current inputs.
//
// Memory handshake: a read or write is issued only in a cycle where
// mem_busy=0. Read data is taken in the first cycle with mem_ready=1.
// pc_inc=0 tells the fetch side to keep instr stable. The decoder relies
// on instr staying unchanged for the whole of a multi-cycle sequence.
//
// Opcode map (instr[6:0]):
//   00 nop  01 mov  02 ldd  03 ldo  04 ldi  05 std  06 sto  07 add
//   08 adi  09 adc  0A sub  0B suc  0C cmp  0D cmi  0E jmp  0F cll
//   10 ret  11 push 12 pop  13 iret 14 sei  15 cli  others: nop
// Operand use: loads address via ALU from fo (ldo adds the immediate).
// Stores address via ALU from so (sto adds the immediate), data from fo.
module seq_decoder #(
  parameter int REG_CNT   = 8,
  parameter int REG_SEL_W = 3,
  parameter int FLAG_W    = 5,
  parameter int IRQ_EN    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        instr,
  input  logic               mem_busy,
  input  logic               mem_ready,
  input  logic [FLAG_W-1:0]  flags,
  input  logic               irq,
  output logic               pc_inc,
  output logic               pc_ie,
  output logic               min_pc,
  output logic               int_vec_sel,
  output logic               reg_in_mux_ctl,
  output logic               alu_r_mux_ctl,
  output logic               alu_cin,
  output logic               alu_flags_ie,
  output logic               ram_write,
  output logic               ram_read,
  output logic               mem_sp,
  output logic               mdata_sp,
  output logic               sp_inc,
  output logic               sp_dec,
  output logic [3:0]         alu_mode,
  output logic [3:0]         reg_l_ctl,
  output logic [3:0]         reg_r_ctl,
  output logic [REG_CNT-1:0] gp_reg_ie,
  output logic               irq_ack,
  output logic               int_en,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    ST_EXEC     = 3'd0,
    ST_RDWAIT   = 3'd1,
    ST_LONG     = 3'd2,
    ST_INT_PUSH = 3'd3,
    ST_INT_JMP  = 3'd4
  } state_t;

  localparam logic [6:0] OP_MOV  = 7'h01, OP_LDD  = 7'h02, OP_LDO  = 7'h03,
                         OP_LDI  = 7'h04, OP_STD  = 7'h05, OP_STO  = 7'h06,
                         OP_ADD  = 7'h07, OP_ADI  = 7'h08, OP_ADC  = 7'h09,
                         OP_SUB  = 7'h0A, OP_SUC  = 7'h0B, OP_CMP  = 7'h0C,
                         OP_CMI  = 7'h0D, OP_JMP  = 7'h0E, OP_CLL  = 7'h0F,
                         OP_RET  = 7'h10, OP_PUSH = 7'h11, OP_POP  = 7'h12,
                         OP_IRET = 7'h13, OP_SEI  = 7'h14, OP_CLI  = 7'h15;

  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001,
                         ALU_PASS_L = 4'b1001, ALU_PASS_IMM = 4'b1010;

  localparam bit IRQ_ON = (IRQ_EN != 0);

  state_t state, state_next;
  logic   ie, ie_next;

  logic [6:0]           opcode;
  logic [REG_SEL_W-1:0] tg, fo, so;
  logic [3:0]           sel_fo, sel_so;
  logic [REG_CNT-1:0]   tg_onehot;
  logic                 ld_off, st_off, is_ret, irq_take, jmp_take;
  logic                 unused_flags;

  assign opcode    = instr[6:0];
  assign tg        = instr[9:7];
  assign fo        = instr[12:10];
  assign so        = instr[15:13];
  assign sel_fo    = 4'(fo);
  assign sel_so    = 4'(so);
  assign tg_onehot = REG_CNT'(1) << tg;
  assign ld_off    = (opcode == OP_LDO);
  assign st_off    = (opcode == OP_STO);
  assign is_ret    = (opcode == OP_RET) || (opcode == OP_IRET);
  assign irq_take  = IRQ_ON && irq && ie;
  assign unused_flags = ^flags;

  assign int_en    = ie && !rst;
  assign state_dbg = rst ? 3'd0 : state;

  // Jump condition decode from instr[10:7]; unlisted codes jump always.
  always_comb begin
    case (instr[10:7])
      4'b0001:         jmp_take = flags[1];
      4'b0010:         jmp_take = flags[0];
      4'b0011:         jmp_take = flags[2];
      4'b0100:         jmp_take = !(flags[2] || flags[0]);
      4'b0101:         jmp_take = flags[2] || flags[0];
      4'b0110:         jmp_take = !flags[2];
      4'b0111:         jmp_take = !flags[0];
      4'b1000, 4'b1001: jmp_take = flags[3];
      default:         jmp_take = 1'b1;
    endcase
  end

  // Step state and interrupt-enable register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EXEC;
      ie    <= 1'b0;
    end else begin
      state <= state_next;
      ie    <= ie_next;
    end
  end

  // Next-state and control-output decode.
  always_comb begin
    pc_inc = 1'b1;        pc_ie = 1'b0;         min_pc = 1'b0;
    int_vec_sel = 1'b0;   reg_in_mux_ctl = 1'b0; alu_r_mux_ctl = 1'b0;
    alu_cin = 1'b0;       alu_flags_ie = 1'b0;  ram_write = 1'b0;
    ram_read = 1'b0;      mem_sp = 1'b0;        mdata_sp = 1'b0;
    sp_inc = 1'b0;        sp_dec = 1'b0;        irq_ack = 1'b0;
    alu_mode = 4'b0000;   reg_l_ctl = 4'd0;     reg_r_ctl = 4'd0;
    gp_reg_ie = '0;
    state_next = state;
    ie_next = ie;
    if (rst) begin
      pc_inc = 1'b0;
      state_next = ST_EXEC;
      ie_next = 1'b0;
    end else begin
      case (state)
        ST_EXEC: begin
          if (irq_take) begin
            // Pre-empt: nothing of instr is executed, PC still points at it.
            pc_inc = 1'b0;
            state_next = ST_INT_PUSH;
          end else begin
            case (opcode)
              OP_MOV: begin
                alu_mode = ALU_PASS_L; reg_l_ctl = sel_fo; gp_reg_ie = tg_onehot;
              end
              OP_LDI: begin
                alu_mode = ALU_PASS_IMM; alu_r_mux_ctl = 1'b1; gp_reg_ie = tg_onehot;
              end
              OP_ADD, OP_ADC, OP_ADI, OP_SUB, OP_SUC, OP_CMP, OP_CMI: begin
                alu_mode = (opcode == OP_ADD || opcode == OP_ADC || opcode == OP_ADI)
                           ? ALU_ADD : ALU_SUB;
                reg_l_ctl = sel_fo;
                if (opcode == OP_ADI || opcode == OP_CMI) alu_r_mux_ctl = 1'b1;
                else reg_r_ctl = sel_so;
                if (opcode == OP_ADC || opcode == OP_SUC) alu_cin = flags[1];
                alu_flags_ie = 1'b1;
                if (opcode != OP_CMP && opcode != OP_CMI) gp_reg_ie = tg_onehot;
              end
              OP_JMP: begin
                if (jmp_take) begin
                  pc_ie = 1'b1;
                  pc_inc = 1'b0;
                end
              end
              OP_LDD, OP_LDO: begin
                reg_l_ctl = sel_fo;
                alu_mode = ld_off ? ALU_ADD : ALU_PASS_L;
                alu_r_mux_ctl = ld_off;
                pc_inc = 1'b0;
                if (!mem_busy) begin
                  ram_read = 1'b1;
                  state_next = ST_RDWAIT;
                end
              end
              OP_STD, OP_STO: begin
                reg_l_ctl = sel_so;
                reg_r_ctl = sel_fo;
                alu_mode = st_off ? ALU_ADD : ALU_PASS_L;
                alu_r_mux_ctl = st_off;
                ram_write = !mem_busy;
                pc_inc = !mem_busy;
              end
              OP_PUSH: begin
                reg_r_ctl = sel_fo;
                mem_sp = 1'b1;
                if (mem_busy) pc_inc = 1'b0;
                else begin
                  ram_write = 1'b1;
                  sp_dec = 1'b1;
                end
              end
              OP_POP, OP_RET, OP_IRET: begin
                sp_inc = 1'b1;
                pc_inc = 1'b0;
                state_next = ST_LONG;
              end
              OP_CLL: begin
                mem_sp = 1'b1;
                mdata_sp = 1'b1;
                pc_inc = 1'b0;
                if (!mem_busy) begin
                  ram_write = 1'b1;
                  sp_dec = 1'b1;
                  state_next = ST_LONG;
                end
              end
              OP_SEI: if (IRQ_ON) ie_next = 1'b1;
              OP_CLI: ie_next = 1'b0;
              default: ;
            endcase
          end
        end
        ST_LONG: begin
          pc_inc = 1'b0;
          if (opcode == OP_CLL) begin
            pc_ie = 1'b1;
            state_next = ST_EXEC;
          end else begin
            // pop / ret / iret: read the word at SP.
            mem_sp = 1'b1;
            if (!mem_busy) begin
              ram_read = 1'b1;
              state_next = ST_RDWAIT;
            end
          end
        end
        ST_RDWAIT: begin
          pc_inc = 1'b0;
          if (opcode == OP_LDD || opcode == OP_LDO) begin
            reg_l_ctl = sel_fo;
            alu_mode = ld_off ? ALU_ADD : ALU_PASS_L;
            alu_r_mux_ctl = ld_off;
          end else begin
            mem_sp = 1'b1;
          end
          if (mem_ready) begin
            state_next = ST_EXEC;
            if (is_ret) begin
              min_pc = 1'b1;
              pc_ie = 1'b1;
              if (IRQ_ON && opcode == OP_IRET) ie_next = 1'b1;
            end else begin
              reg_in_mux_ctl = 1'b1;
              gp_reg_ie = tg_onehot;
              pc_inc = 1'b1;
            end
          end
        end
        ST_INT_PUSH: begin
          pc_inc = 1'b0;
          mem_sp = 1'b1;
          mdata_sp = 1'b1;
          if (!mem_busy) begin
            ram_write = 1'b1;
            sp_dec = 1'b1;
            state_next = ST_INT_JMP;
          end
        end
        ST_INT_JMP: begin
          pc_inc = 1'b0;
          pc_ie = 1'b1;
          int_vec_sel = 1'b1;
          irq_ack = 1'b1;
          ie_next = 1'b0;
          state_next = ST_EXEC;
        end
        default: begin
          pc_inc = 1'b0;
          state_next = ST_EXEC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_decoder.sv
// Directed bench for seq_decoder. The driver applies one input vector per
// cycle and queues the hand-computed output word for that cycle; the
// monitor pops and compares on the falling edge.
module tb_seq_decoder;

  localparam int W = 36;  // {alu_mode, reg_l, reg_r, gp_reg_ie, strobes[15:0]}

  localparam logic [15:0] S_INC = 16'h0001, S_PCIE = 16'h0002, S_MIN = 16'h0004,
                          S_VEC = 16'h0008, S_RIN = 16'h0010, S_RMUX = 16'h0020,
                          S_CIN = 16'h0040, S_FIE = 16'h0080, S_WR = 16'h0100,
                          S_RD = 16'h0200, S_MSP = 16'h0400, S_MDSP = 16'h0800,
                          S_SPI = 16'h1000, S_SPD = 16'h2000, S_ACK = 16'h4000,
                          S_IE = 16'h8000;

  localparam logic [3:0] A_ADD = 4'b0000, A_SUB = 4'b0001, A_PL = 4'b1001, A_PI = 4'b1010;

  localparam logic [6:0] OP_NOP = 7'h00, OP_MOV = 7'h01, OP_LDD = 7'h02, OP_LDO = 7'h03,
                         OP_LDI = 7'h04, OP_STD = 7'h05, OP_STO = 7'h06, OP_ADD = 7'h07,
                         OP_ADI = 7'h08, OP_ADC = 7'h09, OP_SUB = 7'h0A, OP_SUC = 7'h0B,
                         OP_CMP = 7'h0C, OP_CMI = 7'h0D, OP_JMP = 7'h0E, OP_CLL = 7'h0F,
                         OP_RET = 7'h10, OP_PUSH = 7'h11, OP_POP = 7'h12, OP_IRET = 7'h13,
                         OP_SEI = 7'h14, OP_CLI = 7'h15;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] instr = 16'h0;
  logic        mem_busy = 1'b0, mem_ready = 1'b0, irq = 1'b0;
  logic [4:0]  flags = 5'h0;

  logic pc_inc, pc_ie, min_pc, int_vec_sel, reg_in_mux_ctl, alu_r_mux_ctl, alu_cin;
  logic alu_flags_ie, ram_write, ram_read, mem_sp, mdata_sp, sp_inc, sp_dec, irq_ack, int_en;
  logic [3:0] alu_mode, reg_l_ctl, reg_r_ctl;
  logic [7:0] gp_reg_ie;
  logic [2:0] state_dbg;

  seq_decoder dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_busy(mem_busy), .mem_ready(mem_ready),
    .flags(flags), .irq(irq), .pc_inc(pc_inc), .pc_ie(pc_ie), .min_pc(min_pc),
    .int_vec_sel(int_vec_sel), .reg_in_mux_ctl(reg_in_mux_ctl),
    .alu_r_mux_ctl(alu_r_mux_ctl), .alu_cin(alu_cin), .alu_flags_ie(alu_flags_ie),
    .ram_write(ram_write), .ram_read(ram_read), .mem_sp(mem_sp), .mdata_sp(mdata_sp),
    .sp_inc(sp_inc), .sp_dec(sp_dec), .alu_mode(alu_mode), .reg_l_ctl(reg_l_ctl),
    .reg_r_ctl(reg_r_ctl), .gp_reg_ie(gp_reg_ie), .irq_ack(irq_ack), .int_en(int_en),
    .state_dbg(state_dbg)
  );

  logic [W-1:0] obs;
  assign obs = {alu_mode, reg_l_ctl, reg_r_ctl, gp_reg_ie,
                int_en, irq_ack, sp_dec, sp_inc, mdata_sp, mem_sp, ram_read, ram_write,
                alu_flags_ie, alu_cin, alu_r_mux_ctl, reg_in_mux_ctl, int_vec_sel,
                min_pc, pc_ie, pc_inc};

  // scoreboard
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_pass = 0;
  logic [W-1:0] mon_e;
  string        mon_nm;

  function automatic logic [15:0] mk(input logic [6:0] op, input logic [2:0] tg,
                                     input logic [2:0] fo, input logic [2:0] so);
    return {so, fo, tg, op};
  endfunction

  function automatic logic [W-1:0] ex(input logic [15:0] s, input logic [3:0] am,
                                      input logic [3:0] l, input logic [3:0] r,
                                      input logic [7:0] g);
    return {am, l, r, g, s};
  endfunction

  // driver: one cycle of stimulus plus its expected output word
  task automatic cyc(input logic r, input logic [15:0] i, input logic b, input logic rdy,
                     input logic [4:0] f, input logic q, input logic [W-1:0] e,
                     input string nm);
    @(posedge clk);
    #1;
    rst = r; instr = i; mem_busy = b; mem_ready = rdy; flags = f; irq = q;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      n_checks++;
      if (obs === mon_e) n_pass++;
      else $display("FAIL %s: got %h expected %h", mon_nm, obs, mon_e);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  logic [15:0] i_add, i_ldd;

  initial begin
    i_add = mk(OP_ADD, 3'd2, 3'd1, 3'd4);
    i_ldd = mk(OP_LDD, 3'd3, 3'd2, 3'd0);

    // reset, then plain ALU ops
    cyc(1, i_add, 0, 0, 5'h00, 0, ex(16'h0, 0, 0, 0, 0), "rst0");
    cyc(1, i_add, 0, 0, 5'h00, 1, ex(16'h0, 0, 0, 0, 0), "rst1");
    cyc(0, i_add, 0, 0, 5'h00, 0, ex(S_INC|S_FIE, A_ADD, 1, 4, 8'h04), "add");
    cyc(0, mk(OP_ADC, 1, 2, 3), 0, 0, 5'h02, 0, ex(S_INC|S_FIE|S_CIN, A_ADD, 2, 3, 8'h02), "adc");
    cyc(0, mk(OP_SUC, 5, 0, 7), 0, 0, 5'h00, 0, ex(S_INC|S_FIE, A_SUB, 0, 7, 8'h20), "suc");
    cyc(0, mk(OP_LDI, 6, 0, 0), 0, 0, 5'h00, 0, ex(S_INC|S_RMUX, A_PI, 0, 0, 8'h40), "ldi");
    cyc(0, mk(OP_MOV, 7, 3, 0), 0, 0, 5'h00, 0, ex(S_INC, A_PL, 3, 0, 8'h80), "mov");
    cyc(0, mk(OP_CMP, 0, 1, 2), 0, 0, 5'h00, 0, ex(S_INC|S_FIE, A_SUB, 1, 2, 8'h00), "cmp");
    cyc(0, mk(OP_CMI, 0, 4, 0), 0, 0, 5'h00, 0, ex(S_INC|S_FIE|S_RMUX, A_SUB, 4, 0, 8'h00), "cmi");
    cyc(0, mk(OP_ADI, 0, 5, 0), 0, 0, 5'h00, 0, ex(S_INC|S_FIE|S_RMUX, A_ADD, 5, 0, 8'h01), "adi");
    cyc(0, mk(OP_SUB, 3, 6, 1), 0, 0, 5'h00, 0, ex(S_INC|S_FIE, A_SUB, 6, 1, 8'h08), "sub");

    // jumps
    cyc(0, mk(OP_JMP, 7, 0, 0), 0, 0, 5'h01, 0, ex(S_INC, 0, 0, 0, 0), "jmp_nz_z1");
    cyc(0, mk(OP_JMP, 7, 0, 0), 0, 0, 5'h00, 0, ex(S_PCIE, 0, 0, 0, 0), "jmp_nz_z0");
    cyc(0, mk(OP_JMP, 1, 0, 0), 0, 0, 5'h02, 0, ex(S_PCIE, 0, 0, 0, 0), "jmp_c");
    cyc(0, mk(OP_JMP, 3, 0, 0), 0, 0, 5'h00, 0, ex(S_INC, 0, 0, 0, 0), "jmp_lt");
    cyc(0, mk(OP_JMP, 4, 0, 0), 0, 0, 5'h04, 0, ex(S_INC, 0, 0, 0, 0), "jmp_gt");
    cyc(0, mk(OP_JMP, 0, 1, 0), 0, 0, 5'h08, 0, ex(S_PCIE, 0, 0, 0, 0), "jmp_user");
    cyc(0, mk(OP_JMP, 0, 0, 0), 0, 0, 5'h00, 0, ex(S_PCIE, 0, 0, 0, 0), "jmp_always");

    // ldd with two busy cycles and late ready
    cyc(0, i_ldd, 1, 0, 5'h00, 0, ex(16'h0, A_PL, 2, 0, 0), "ldd_stall0");
    cyc(0, i_ldd, 1, 0, 5'h00, 0, ex(16'h0, A_PL, 2, 0, 0), "ldd_stall1");
    cyc(0, i_ldd, 0, 0, 5'h00, 0, ex(S_RD, A_PL, 2, 0, 0), "ldd_read");
    cyc(0, i_ldd, 0, 0, 5'h00, 0, ex(16'h0, A_PL, 2, 0, 0), "ldd_wait0");
    cyc(0, i_ldd, 0, 0, 5'h00, 0, ex(16'h0, A_PL, 2, 0, 0), "ldd_wait1");
    cyc(0, i_ldd, 0, 1, 5'h00, 0, ex(S_INC|S_RIN, A_PL, 2, 0, 8'h08), "ldd_done");
    cyc(0, mk(OP_LDO, 1, 4, 0), 0, 0, 5'h00, 0, ex(S_RD|S_RMUX, A_ADD, 4, 0, 0), "ldo_read");
    cyc(0, mk(OP_LDO, 1, 4, 0), 0, 1, 5'h00, 0, ex(S_INC|S_RIN|S_RMUX, A_ADD, 4, 0, 8'h02), "ldo_done");

    // stores, push, pop
    cyc(0, mk(OP_STD, 0, 3, 5), 1, 0, 5'h00, 0, ex(16'h0, A_PL, 5, 3, 0), "std_stall");
    cyc(0, mk(OP_STD, 0, 3, 5), 0, 0, 5'h00, 0, ex(S_WR|S_INC, A_PL, 5, 3, 0), "std");
    cyc(0, mk(OP_STO, 0, 2, 1), 0, 0, 5'h00, 0, ex(S_WR|S_INC|S_RMUX, A_ADD, 1, 2, 0), "sto");
    cyc(0, mk(OP_PUSH, 0, 6, 0), 1, 0, 5'h00, 0, ex(S_MSP, 0, 0, 6, 0), "push_stall");
    cyc(0, mk(OP_PUSH, 0, 6, 0), 0, 0, 5'h00, 0, ex(S_WR|S_MSP|S_SPD|S_INC, 0, 0, 6, 0), "push");
    cyc(0, mk(OP_POP, 4, 0, 0), 0, 0, 5'h00, 0, ex(S_SPI, 0, 0, 0, 0), "pop_spinc");
    cyc(0, mk(OP_POP, 4, 0, 0), 1, 0, 5'h00, 0, ex(S_MSP, 0, 0, 0, 0), "pop_stall");
    cyc(0, mk(OP_POP, 4, 0, 0), 0, 0, 5'h00, 0, ex(S_MSP|S_RD, 0, 0, 0, 0), "pop_read");
    cyc(0, mk(OP_POP, 4, 0, 0), 0, 1, 5'h00, 0, ex(S_MSP|S_RIN|S_INC, 0, 0, 0, 8'h10), "pop_done");

    // cll / ret
    cyc(0, mk(OP_CLL, 0, 0, 0), 0, 0, 5'h00, 0, ex(S_MSP|S_MDSP|S_WR|S_SPD, 0, 0, 0, 0), "cll_push");
    cyc(0, mk(OP_CLL, 0, 0, 0), 0, 0, 5'h00, 0, ex(S_PCIE, 0, 0, 0, 0), "cll_jump");
    cyc(0, mk(OP_RET, 0, 0, 0), 0, 0, 5'h00, 0, ex(S_SPI, 0, 0, 0, 0), "ret_spinc");
    cyc(0, mk(OP_RET, 0, 0, 0), 0, 0, 5'h00, 0, ex(S_MSP|S_RD, 0, 0, 0, 0), "ret_read");
    cyc(0, mk(OP_RET, 0, 0, 0), 0, 1, 5'h00, 0, ex(S_MSP|S_MIN|S_PCIE, 0, 0, 0, 0), "ret_done");
    cyc(0, mk(7'h7F, 1, 2, 3), 0, 0, 5'h00, 0, ex(S_INC, 0, 0, 0, 0), "undef_nop");

    // interrupt during a pending ldd
    cyc(0, mk(OP_SEI, 0, 0, 0), 0, 0, 5'h00, 0, ex(S_INC, 0, 0, 0, 0), "sei");
    cyc(0, i_ldd, 0, 0, 5'h00, 0, ex(S_IE|S_RD, A_PL, 2, 0, 0), "irq_ldd_read");
    cyc(0, i_ldd, 0, 0, 5'h00, 1, ex(S_IE, A_PL, 2, 0, 0), "irq_ldd_wait");
    cyc(0, i_ldd, 0, 1, 5'h00, 1, ex(S_IE|S_INC|S_RIN, A_PL, 2, 0, 8'h08), "irq_ldd_done");
    cyc(0, i_add, 0, 0, 5'h00, 1, ex(S_IE, 0, 0, 0, 0), "irq_preempt");
    cyc(0, i_add, 1, 0, 5'h00, 1, ex(S_IE|S_MSP|S_MDSP, 0, 0, 0, 0), "irq_push_stall");
    cyc(0, i_add, 0, 0, 5'h00, 1, ex(S_IE|S_MSP|S_MDSP|S_WR|S_SPD, 0, 0, 0, 0), "irq_push");
    cyc(0, i_add, 0, 0, 5'h00, 1, ex(S_IE|S_PCIE|S_VEC|S_ACK, 0, 0, 0, 0), "irq_jmp");
    cyc(0, i_add, 0, 0, 5'h00, 1, ex(S_INC|S_FIE, A_ADD, 1, 4, 8'h04), "irq_masked");
    cyc(0, mk(OP_IRET, 0, 0, 0), 0, 0, 5'h00, 0, ex(S_SPI, 0, 0, 0, 0), "iret_spinc");
    cyc(0, mk(OP_IRET, 0, 0, 0), 0, 0, 5'h00, 0, ex(S_MSP|S_RD, 0, 0, 0, 0), "iret_read");
    cyc(0, mk(OP_IRET, 0, 0, 0), 0, 1, 5'h00, 0, ex(S_MSP|S_MIN|S_PCIE, 0, 0, 0, 0), "iret_done");
    cyc(0, i_add, 0, 0, 5'h00, 0, ex(S_IE|S_INC|S_FIE, A_ADD, 1, 4, 8'h04), "iret_ie");
    cyc(0, mk(OP_CLI, 0, 0, 0), 0, 0, 5'h00, 0, ex(S_IE|S_INC, 0, 0, 0, 0), "cli");
    cyc(0, mk(OP_NOP, 0, 0, 0), 0, 0, 5'h00, 0, ex(S_INC, 0, 0, 0, 0), "cli_after");

    // reset while waiting for read data
    cyc(0, mk(OP_SEI, 0, 0, 0), 0, 0, 5'h00, 0, ex(S_INC, 0, 0, 0, 0), "sei2");
    cyc(0, i_ldd, 0, 0, 5'h00, 0, ex(S_IE|S_RD, A_PL, 2, 0, 0), "rst_ldd_read");
    cyc(1, i_ldd, 0, 1, 5'h00, 0, ex(16'h0, 0, 0, 0, 0), "rst_rdwait");
    cyc(0, i_add, 0, 0, 5'h00, 1, ex(S_INC|S_FIE, A_ADD, 1, 4, 8'h04), "post_rst_irq");
    cyc(0, mk(OP_NOP, 0, 0, 0), 0, 0, 5'h00, 1, ex(S_INC, 0, 0, 0, 0), "post_rst_nop");

    @(posedge clk);
    @(posedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_decoder.md
Name: seq_decoder

Overview:
- Next-generation instruction decoder for the 16-bit pcpu core.
- Generalised in register count and flag width.
- Replaces implicit, combinational memory-handshake handling with an explicit step state machine that owns all multi-cycle sequences: loads, call/ret, new push/pop, and a new single-source interrupt entry/return path.
- Sits between the instruction register and the datapath (PC, register file, ALU, memory switcher, SP).

Parameters:
- REG_CNT, 8, number of general-purpose registers (width of gp_reg_ie).
- REG_SEL_W, 3, register-select field width (fixed at 3 for the current 16-bit encoding).
- FLAG_W, 5, width of the flags input. Bit0 Z, bit1 C, bit2 N/LT, bit3 user.
- IRQ_EN, 1, 1 = interrupt logic present. 0 = irq ignored, irq_ack tied 0, sei/cli/iret act as nop/ret.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- instr  in  16  current instruction. opcode[6:0], tg[9:7], fo[12:10], so[15:13].
- mem_busy  in  1  memory switcher cannot accept a request
- mem_ready  in  1  read data valid this cycle
- flags  in  FLAG_W  ALU flags
- irq  in  1  level interrupt request
- pc_inc, pc_ie, min_pc, int_vec_sel  out  1 each  PC control. int_vec_sel loads the fixed vector.
- reg_in_mux_ctl, alu_r_mux_ctl, alu_cin, alu_flags_ie  out  1 each  datapath muxes
- ram_write, ram_read, mem_sp, mdata_sp, sp_inc, sp_dec  out  1 each  memory/stack control
- alu_mode  out  4  ALU operation
- reg_l_ctl, reg_r_ctl  out  4  register read selects. Upper bit 0.
- gp_reg_ie  out  REG_CNT  one-hot register write enable
- irq_ack  out  1  one-cycle acknowledge
- int_en  out  1  current interrupt-enable state

Behaviour:
- Registered state:
  - step FSM: ST_EXEC, ST_RDWAIT, ST_LONG, ST_INT_PUSH, ST_INT_JMP.
  - ie bit.
- All other outputs are combinational from state, instr, mem_busy, mem_ready, flags and irq.
- While rst=1, every output is 0, including pc_inc. On the first rising edge with rst=1: state becomes ST_EXEC and ie becomes 0. A reset mid-sequence aborts the sequence with no further memory strobe.
- Default in every state: all outputs 0 except pc_inc=1.
- instr must stay stable while pc_inc=0.
- Single-cycle ops in ST_EXEC (mov, ldi, add, adi, adc, sub, suc, cmp, cmi, jmp): same encodings and ALU modes as the current decoder.
  - alu_mode: 1001 pass-L, 1010 pass-imm, 0000 add, 0001 sub.
  - adc/suc drive alu_cin from flags[1].
- jmp condition from instr[10:7]:
  - 0001 C, 0010 Z, 0011 LT, 0100 !(LT|Z), 0101 LT|Z, 0110 !LT, 0111 !Z, 1000/1001 flags[3], other always.
  - Taken: pc_ie=1, pc_inc=0.
- Loads (ldd 0x02, ldo 0x03), pop 0x12:
  - ST_EXEC: if mem_busy, hold the address outputs with pc_inc=0. Else assert ram_read for 1 cycle, pc_inc=0, go to ST_RDWAIT.
  - Exception: pop first asserts sp_inc (pc_inc=0) and goes to ST_LONG; ST_LONG then issues the read with mem_sp=1 and goes to ST_RDWAIT.
  - ST_RDWAIT: address outputs are held.
    - mem_ready=0: pc_inc=0.
    - mem_ready=1: reg_in_mux_ctl=1, gp_reg_ie[tg]=1, pc_inc=1, go to ST_EXEC.
- Stores (std 0x05, sto 0x06), push 0x11:
  - Stores are posted.
  - If mem_busy: hold, pc_inc=0.
  - Else: ram_write=1 with data from fo, pc_inc=1.
  - push additionally sets mem_sp=1 and sp_dec=1, with data from fo.
- cll 0x0F:
  - ST_EXEC: push PC (mem_sp, mdata_sp, ram_write, sp_dec, pc_inc=0), stalling while mem_busy. Then go to ST_LONG.
  - ST_LONG: pc_ie=1 from the immediate, then go to ST_EXEC.
- ret 0x10, iret 0x13:
  - ST_EXEC: sp_inc, pc_inc=0, go to ST_LONG.
  - ST_LONG: mem_sp and ram_read (stall while busy), go to ST_RDWAIT.
  - ST_RDWAIT with mem_ready: min_pc=1, pc_ie=1, pc_inc=0, go to ST_EXEC.
  - iret also sets ie=1 on that edge.
- sei 0x14 sets ie; cli 0x15 clears ie. Both are single-cycle.
- Interrupt entry:
  - Condition: IRQ_EN=1, state ST_EXEC, irq=1, ie=1.
  - Takes priority over executing instr. The instruction is not executed and all its strobes are suppressed.
  - pc_inc=0, go to ST_INT_PUSH.
  - ST_INT_PUSH: push PC as in cll (stall while busy), go to ST_INT_JMP.
  - ST_INT_JMP: pc_ie=1, int_vec_sel=1, irq_ack=1, ie cleared, go to ST_EXEC.
  - The pushed PC is the address of the pre-empted instruction.
- sei followed by pending irq: the interrupt is taken at the next ST_EXEC, never mid-sequence.
- Undefined opcodes behave as nop.

Test Plan:
- Reset: hold rst 2 cycles with instr=add. All outputs 0. First post-reset cycle: gp_reg_ie[tg]=1, pc_inc=1.
- ldd tg=3 with mem_busy=1 for 2 cycles, then ready after 3 cycles:
  - Stall cycles: pc_inc=0.
  - Exactly one ram_read pulse, then pc_inc=0 in ST_RDWAIT.
  - On ready: gp_reg_ie=0x08, pc_inc=1.
- cll then ret, mem_busy=0, ready 1 cycle after read:
  - cll: one ram_write+sp_dec, then pc_ie.
  - ret: sp_inc, ram_read, then min_pc+pc_ie. Total 2 and 3 cycles respectively.
- jmp instr[10:7]=0111 with flags Z=1 -> pc_inc=1, pc_ie=0. With Z=0 -> pc_ie=1.
- sei, then irq=1 during a pending ldd -> ldd completes, the next instruction is pre-empted, push, then the cycle with int_vec_sel=irq_ack=pc_ie=1. int_en=0 afterwards. iret restores int_en=1.
- rst asserted in ST_RDWAIT -> no write enable. The next cycle is in ST_EXEC with ie=0 and irq ignored.
